// File: rtl/ex_pipe_pkg.sv
// Shared constants for the decode->execute pipeline register: control bundle
// field positions, operand word indices and ALU operation encodings.
package ex_pipe_pkg;

    localparam int CTRL_W   = 10;
    localparam int DATA_W   = 16;
    localparam int NUM_DATA = 7;
    localparam int CNT_W    = 16;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_ALUSRC    = 1;
    localparam int CTRL_ALUOP_LSB = 2;
    localparam int CTRL_ALUOP_MSB = 4;
    localparam int CTRL_BRANCH    = 5;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_REGSTORE  = 8;

    localparam int OP_ARG1 = 0;
    localparam int OP_ARG2 = 1;
    localparam int OP_ARG3 = 2;
    localparam int OP_IMM  = 3;
    localparam int OP_RS1  = 4;
    localparam int OP_RS2  = 5;
    localparam int OP_RD   = 6;

    typedef enum logic [2:0] {
        ALUOP_ADD = 3'd0,
        ALUOP_SUB = 3'd1,
        ALUOP_AND = 3'd2,
        ALUOP_OR  = 3'd3,
        ALUOP_XOR = 3'd4,
        ALUOP_SLT = 3'd5,
        ALUOP_SLL = 3'd6,
        ALUOP_SRL = 3'd7
    } aluop_e;

    function automatic aluop_e ctrl_aluop(input logic [CTRL_W-1:0] ctrl);
        return aluop_e'(ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB]);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register. The low ZERO_W payload bits (the control bundle)
// are zeroed whenever the slot is invalidated so downstream sees a clean bubble.
module pipe_slot #(
    parameter int W      = 8,
    parameter int ZERO_W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_r;
    logic [W-1:0] q_r;

    // Slot state: reset > flush > load > clear > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            q_r     <= {W{1'b0}};
        end else if (flush || (clear && !load)) begin
            valid_r           <= 1'b0;
            q_r[ZERO_W-1:0]   <= {ZERO_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            q_r     <= d;
        end else begin
            valid_r <= valid_r;
            q_r     <= q_r;
        end
    end

    assign valid = valid_r;
    assign q     = q_r;

endmodule

// File: rtl/ex_pipe_reg.sv
// Decode->execute pipeline register with valid/ready handshake, optional skid
// slot, synchronous flush and a saturating stall counter.
module ex_pipe_reg
    import ex_pipe_pkg::*;
#(
    parameter int CTRL_W   = ex_pipe_pkg::CTRL_W,
    parameter int DATA_W   = ex_pipe_pkg::DATA_W,
    parameter int NUM_DATA = ex_pipe_pkg::NUM_DATA,
    parameter int SKID     = 1,
    parameter int CNT_W    = ex_pipe_pkg::CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int PAY_W = CTRL_W + NUM_DATA * DATA_W;

    logic [PAY_W-1:0] in_payload_s;
    logic [PAY_W-1:0] main_d_s;
    logic [PAY_W-1:0] main_q_s;
    logic             main_valid_s;
    logic             main_load_s;
    logic             main_clear_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [CNT_W-1:0] stall_cnt_r;

    // Flush blocks acceptance even when in_ready is high.
    assign in_payload_s = {in_data, in_ctrl};
    assign in_fire_s    = in_valid && in_ready && !flush;
    assign out_fire_s   = main_valid_s && out_ready;

    pipe_slot #(.W(PAY_W), .ZERO_W(CTRL_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (main_load_s),
        .clear (main_clear_s),
        .d     (main_d_s),
        .valid (main_valid_s),
        .q     (main_q_s)
    );

    if (SKID != 0) begin : g_skid
        logic             skid_valid_s;
        logic [PAY_W-1:0] skid_q_s;
        logic             skid_load_s;
        logic             skid_clear_s;

        // in_ready comes straight from the skid flag, so out_ready never reaches it.
        assign in_ready = !skid_valid_s;

        // Steering: main refills from skid first (FIFO order), else from the input.
        always_comb begin
            main_load_s  = (!main_valid_s || out_fire_s) && (skid_valid_s || in_fire_s);
            main_clear_s = out_fire_s;
            main_d_s     = skid_valid_s ? skid_q_s : in_payload_s;
            skid_load_s  = in_fire_s && main_valid_s && !out_fire_s;
            skid_clear_s = out_fire_s;
        end

        pipe_slot #(.W(PAY_W), .ZERO_W(CTRL_W)) u_skid (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .load  (skid_load_s),
            .clear (skid_clear_s),
            .d     (in_payload_s),
            .valid (skid_valid_s),
            .q     (skid_q_s)
        );
    end else begin : g_single
        assign in_ready = !main_valid_s || out_ready;

        // Single slot: load on accept, empty when the entry leaves with nothing behind it.
        always_comb begin
            main_load_s  = in_fire_s;
            main_clear_s = out_fire_s;
            main_d_s     = in_payload_s;
        end
    end

    // Saturating count of stalled cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (main_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign out_valid = main_valid_s;
    assign out_ctrl  = main_q_s[CTRL_W-1:0];
    assign out_data  = main_q_s[PAY_W-1:CTRL_W];
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_ex_pipe_reg.sv
// Directed self-checking bench for ex_pipe_reg (SKID=1, CNT_W=16).
module tb_ex_pipe_reg;

    localparam int CW = 10;
    localparam int DW = 16;
    localparam int ND = 7;
    localparam int NW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     in_ctrl = '0;
    logic [ND*DW-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CW-1:0]     out_ctrl;
    logic [ND*DW-1:0]  out_data;
    logic [NW-1:0]     stall_cnt;

    int checks = 0;
    int errors = 0;

    ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .NUM_DATA(ND), .SKID(1), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] w0);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = {{((ND-1)*DW){1'b0}}, w0} | ({{((ND-1)*DW){1'b0}}, w0 ^ 16'h5A5A} << (6*DW));
    endtask

    task automatic test_reset();
        reset = 1'b1; offer(10'h3FF, 16'hDEAD); out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 10'h000) begin errors++; $display("FAIL reset_ctrl got %h exp 000", out_ctrl); end
        checks++; if (out_data !== {(ND*DW){1'b0}}) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
        checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h exp 0000", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1; offer(10'h015, 16'hBEEF);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_ctrl !== 10'h015) begin errors++; $display("FAIL single_ctrl got %h exp 015", out_ctrl); end
        checks++; if (out_data[15:0] !== 16'hBEEF) begin errors++; $display("FAIL single_word0 got %h exp beef", out_data[15:0]); end
        checks++; if (out_data[111:96] !== 16'hE4B5) begin errors++; $display("FAIL single_word6 got %h exp e4b5", out_data[111:96]); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 10'h000) begin errors++; $display("FAIL single_drain_ctrl got %h exp 000", out_ctrl); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
            offer(10'(i + 1), 16'(16'h1000 + i));
            step();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== 10'(i + 1)) begin errors++; $display("FAIL b2b_ctrl[%0d] got %b/%h exp 1/%h", i, out_valid, out_ctrl, 10'(i + 1)); end
            checks++; if (out_data[15:0] !== 16'(16'h1000 + i)) begin errors++; $display("FAIL b2b_word0[%0d] got %h exp %h", i, out_data[15:0], 16'(16'h1000 + i)); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", out_valid); end
        checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL b2b_cnt got %h exp 0000", stall_cnt); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        offer(10'h0A1, 16'hAAAA);
        step();
        checks++; if (out_ctrl !== 10'h0A1) begin errors++; $display("FAIL skid_a_main got %h exp 0a1", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_before_b got %b exp 1", in_ready); end
        offer(10'h0B2, 16'hBBBB);
        step();
        in_valid = 1'b0;
        checks++; if (out_ctrl !== 10'h0A1 || out_data[15:0] !== 16'hAAAA) begin errors++; $display("FAIL skid_a_held got %h/%h exp 0a1/aaaa", out_ctrl, out_data[15:0]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got %b exp 0", in_ready); end
        step();
        checks++; if (out_ctrl !== 10'h0A1 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_hold got %h/%b exp 0a1/0", out_ctrl, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 10'h0B2 || out_data[15:0] !== 16'hBBBB) begin errors++; $display("FAIL skid_b_out got %b/%h/%h exp 1/0b2/bbbb", out_valid, out_ctrl, out_data[15:0]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_rise got %b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(10'h0D4, 16'hDDDD); step();
        offer(10'h0E5, 16'hEEEE); step();
        checks++; if (in_ready !== 1'b0 || out_ctrl !== 10'h0D4) begin errors++; $display("FAIL flush_prefill got %b/%h exp 0/0d4", in_ready, out_ctrl); end
        flush = 1'b1; offer(10'h0C3, 16'hCCCC);
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h000) begin errors++; $display("FAIL flush_bubble got %b/%h exp 0/000", out_valid, out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        // Flush with in_ready high: the offered entry must still be dropped.
        flush = 1'b1; offer(10'h0C7, 16'hC7C7);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_c[%0d] got %b/%h exp 0/000", i, out_valid, out_ctrl); end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall_saturate();
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b0;
        offer(10'h0F6, 16'hF00D); step(); in_valid = 1'b0;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", stall_cnt); end
        repeat (100) step();
        checks++; if (stall_cnt !== 16'd100) begin errors++; $display("FAIL sat_100 got %0d exp 100", stall_cnt); end
        repeat (65435) step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", stall_cnt); end
        repeat (4465) step();
        checks++; if (stall_cnt !== 16'hFFFF || out_ctrl !== 10'h0F6) begin errors++; $display("FAIL sat_hold got %h/%h exp ffff/0f6", stall_cnt, out_ctrl); end
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0) begin errors++; $display("FAIL sat_flush got %h/%b exp ffff/0", stall_cnt, out_valid); end
        step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_after_flush got %h exp ffff", stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        offer(10'h111, 16'h1111); step();
        offer(10'h122, 16'h2222); step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_prefill got %b/%b exp 0/1", in_ready, out_valid); end
        reset = 1'b1; offer(10'h133, 16'h3333); out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h000 || out_data !== {(ND*DW){1'b0}}) begin errors++; $display("FAIL rst_mid_outputs got %b/%h/%h exp 0/000/0", out_valid, out_ctrl, out_data); end
        checks++; if (stall_cnt !== 16'h0000 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cnt_ready got %h/%b exp 0000/1", stall_cnt, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h000) begin errors++; $display("FAIL rst_mid_leftover got %b/%h exp 0/000", out_valid, out_ctrl); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_skid();
        test_flush();
        test_stall_saturate();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
